cfg_chain_ctrl: RTL and testbench

//  Parametrised successor to the bare config shift register plus output mux.

---
 rtl/cfg_chain_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_ctrl.sv
// Serial configuration loader with CRC-8 check, atomic commit, serial readback
// and a registered output channel mux.
module cfg_chain_ctrl #(
    parameter int unsigned WIDTH = 86,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sh_en,
    input  logic                     sh_din,
    input  logic                     rb_en,
    output logic                     sh_dout,
    output logic                     rb_busy,
    output logic [WIDTH-1:0]         cfg_out,
    output logic                     cfg_valid,
    output logic                     crc_err,
    output logic                     len_err,
    input  logic [$clog2(NCH)-1:0]   ch_sel,
    input  logic [NCH*CW-1:0]        ch_in,
    output logic [CW-1:0]            ch_out
);

    localparam int unsigned SELW = $clog2(NCH);
    localparam int unsigned CNTW = $clog2(WIDTH + 10);
    localparam int unsigned RBW  = $clog2(WIDTH);

    localparam logic [CNTW-1:0] CNT_PAY   = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_FRAME = CNTW'(WIDTH + 8);
    localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(WIDTH + 9);
    localparam logic [RBW-1:0]  RB_LAST   = RBW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        READBACK = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH-1:0]  shadow;
    logic [7:0]        crc;
    logic [7:0]        rx_crc;
    logic [WIDTH-1:0]  rb_reg;
    logic [RBW-1:0]    rb_cnt;
    logic [CW-1:0]     mux_d;

    logic start_frame, shift_bit, commit, rb_start, rb_step, rb_done;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        commit      = 1'b0;
        rb_start    = 1'b0;
        rb_step     = 1'b0;
        rb_done     = 1'b0;
        case (state)
            IDLE: begin
                if (sh_en) begin
                    next_state  = SHIFT;
                    start_frame = 1'b1;
                end else if (rb_en) begin
                    next_state = READBACK;
                    rb_start   = 1'b1;
                end
            end
            SHIFT: begin
                if (sh_en) begin
                    shift_bit = 1'b1;
                end else begin
                    next_state = IDLE;
                    commit     = 1'b1;
                end
            end
            READBACK: begin
                // A frame start pre-empts readback so cfg_out never moves under it.
                if (sh_en) begin
                    next_state  = SHIFT;
                    start_frame = 1'b1;
                end else begin
                    rb_step = 1'b1;
                    if (rb_cnt == RB_LAST) begin
                        rb_done    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            shadow    <= '0;
            crc       <= '0;
            rx_crc    <= '0;
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            rb_reg    <= '0;
            rb_cnt    <= '0;
            rb_busy   <= 1'b0;
        end else begin
            if (start_frame) begin
                cnt     <= CNTW'(1);
                shadow  <= {shadow[WIDTH-2:0], sh_din};
                crc     <= crc_step(8'h00, sh_din);
                crc_err <= 1'b0;
                len_err <= 1'b0;
                rb_busy <= 1'b0;
            end
            if (shift_bit) begin
                if (cnt < CNT_PAY) begin
                    shadow <= {shadow[WIDTH-2:0], sh_din};
                    crc    <= crc_step(crc, sh_din);
                end else if (cnt < CNT_FRAME) begin
                    rx_crc <= {rx_crc[6:0], sh_din};
                end
                if (cnt != CNT_MAX) cnt <= cnt + CNTW'(1);
            end
            if (commit) begin
                if (cnt == CNT_FRAME && rx_crc == crc) begin
                    cfg_out   <= shadow;
                    cfg_valid <= 1'b1;
                end else if (cnt != CNT_FRAME) begin
                    len_err <= 1'b1;
                end else begin
                    crc_err <= 1'b1;
                end
            end
            if (rb_start) begin
                rb_reg  <= cfg_out;
                rb_cnt  <= '0;
                rb_busy <= 1'b1;
            end
            if (rb_step) begin
                rb_reg <= {rb_reg[WIDTH-2:0], 1'b0};
                rb_cnt <= rb_cnt + RBW'(1);
                if (rb_done) rb_busy <= 1'b0;
            end
        end
    end

    assign sh_dout = rb_busy & rb_reg[WIDTH-1];

    always_comb begin
        mux_d = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_sel == SELW'(k)) mux_d = ch_in[k*CW +: CW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ch_out <= '0;
        else        ch_out <= mux_d;
    end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Directed bench for cfg_chain_ctrl: frame table, readback, abort, reset and mux checks.
module tb_cfg_chain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, sh_en, sh_din, rb_en;
    logic [1:0]  ch_sel;
    logic [31:0] ch_in;
    logic [23:0] ch_in3;

    logic        sh_dout, rb_busy, cfg_valid, crc_err, len_err;
    logic [15:0] cfg_out;
    logic [7:0]  ch_out;

    logic        sh_dout3, rb_busy3, cfg_valid3, crc_err3, len_err3;
    logic [15:0] cfg_out3;
    logic [7:0]  ch_out3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cfg_chain_ctrl #(.WIDTH(16), .NCH(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .sh_en(sh_en), .sh_din(sh_din), .rb_en(rb_en),
        .sh_dout(sh_dout), .rb_busy(rb_busy), .cfg_out(cfg_out), .cfg_valid(cfg_valid),
        .crc_err(crc_err), .len_err(len_err), .ch_sel(ch_sel), .ch_in(ch_in), .ch_out(ch_out)
    );

    cfg_chain_ctrl #(.WIDTH(16), .NCH(3), .CW(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .sh_en(1'b0), .sh_din(1'b0), .rb_en(1'b0),
        .sh_dout(sh_dout3), .rb_busy(rb_busy3), .cfg_out(cfg_out3), .cfg_valid(cfg_valid3),
        .crc_err(crc_err3), .len_err(len_err3), .ch_sel(ch_sel), .ch_in(ch_in3), .ch_out(ch_out3)
    );

    typedef struct {
        logic [15:0] payload;
        logic [7:0]  crc;
        int          nbits;
        logic [15:0] exp_cfg;
        logic        exp_crc_err;
        logic        exp_len_err;
    } frame_vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp4;
        logic [7:0] exp3;
    } mux_vec_t;

    frame_vec_t fv[6];
    mux_vec_t   mv[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [15:0] payload, input logic [7:0] crcb, input int nbits);
        logic [23:0] fr;
        fr = {payload, crcb};
        for (int i = 0; i < nbits; i++) begin
            sh_en  = 1'b1;
            sh_din = (i < 24) ? fr[23-i] : i[0];
            tick();
        end
        sh_en  = 1'b0;
        sh_din = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cfg_out"},   32'(cfg_out),   32'h0);
        check({tag, " cfg_valid"}, 32'(cfg_valid), 32'h0);
        check({tag, " crc_err"},   32'(crc_err),   32'h0);
        check({tag, " len_err"},   32'(len_err),   32'h0);
        check({tag, " rb_busy"},   32'(rb_busy),   32'h0);
        check({tag, " sh_dout"},   32'(sh_dout),   32'h0);
        check({tag, " ch_out"},    32'(ch_out),    32'h0);
        check({tag, " ch_out3"},   32'(ch_out3),   32'h0);
    endtask

    initial begin
        logic [15:0] rbexp;
        logic [23:0] fr;

        // 0x1234 has true CRC-8 0xF1; 0x1F is a deliberately wrong check byte.
        fv[0] = '{16'hA5C3, 8'h1E, 24, 16'hA5C3, 1'b0, 1'b0};
        fv[1] = '{16'h1234, 8'h1F, 24, 16'hA5C3, 1'b1, 1'b0};
        fv[2] = '{16'hA5C3, 8'h1E, 23, 16'hA5C3, 1'b0, 1'b1};
        fv[3] = '{16'hA5C3, 8'h1E, 40, 16'hA5C3, 1'b0, 1'b1};
        fv[4] = '{16'h1234, 8'hF1, 24, 16'h1234, 1'b0, 1'b0};
        fv[5] = '{16'hA5C3, 8'h1E, 24, 16'hA5C3, 1'b0, 1'b0};

        mv[0] = '{2'd0, 8'h11, 8'h11};
        mv[1] = '{2'd1, 8'h22, 8'h22};
        mv[2] = '{2'd2, 8'h33, 8'h33};
        mv[3] = '{2'd3, 8'h44, 8'h00};

        rst_n  = 1'b0;
        sh_en  = 1'b0;
        sh_din = 1'b0;
        rb_en  = 1'b0;
        ch_sel = 2'd0;
        ch_in  = {8'h44, 8'h33, 8'h22, 8'h11};
        ch_in3 = {8'h33, 8'h22, 8'h11};
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            send_frame(fv[v].payload, fv[v].crc, fv[v].nbits);
            check($sformatf("frame%0d cfg_out", v),   32'(cfg_out),   32'(fv[v].exp_cfg));
            check($sformatf("frame%0d cfg_valid", v), 32'(cfg_valid), 32'h1);
            check($sformatf("frame%0d crc_err", v),   32'(crc_err),   32'(fv[v].exp_crc_err));
            check($sformatf("frame%0d len_err", v),   32'(len_err),   32'(fv[v].exp_len_err));
        end

        // Full readback; a stray rb_en mid-readback must be ignored.
        rbexp = 16'hA5C3;
        rb_en = 1'b1;
        tick();
        rb_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rb busy c%0d", i), 32'(rb_busy), 32'h1);
            check($sformatf("rb dout c%0d", i), 32'(sh_dout), 32'(rbexp[15-i]));
            rb_en = (i == 3);
            tick();
        end
        rb_en = 1'b0;
        check("rb end busy", 32'(rb_busy), 32'h0);
        check("rb end dout", 32'(sh_dout), 32'h0);
        tick();
        check("rb no requeue", 32'(rb_busy), 32'h0);

        // Readback aborted by a frame start at readback cycle 5.
        fr = {16'h1234, 8'hF1};
        rb_en = 1'b1;
        tick();
        rb_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort dout c%0d", i), 32'(sh_dout), 32'(rbexp[15-i]));
            tick();
        end
        sh_en  = 1'b1;
        sh_din = fr[23];
        tick();
        check("abort busy", 32'(rb_busy), 32'h0);
        check("abort dout", 32'(sh_dout), 32'h0);
        for (int i = 1; i < 24; i++) begin
            sh_din = fr[23-i];
            tick();
        end
        sh_en  = 1'b0;
        sh_din = 1'b0;
        tick();
        check("abort frame cfg_out", 32'(cfg_out), 32'h1234);
        check("abort frame crc_err", 32'(crc_err), 32'h0);
        check("abort frame len_err", 32'(len_err), 32'h0);

        // Output mux, one-cycle latency, both channel counts.
        for (int v = 0; v < 4; v++) begin
            ch_sel = mv[v].sel;
            tick();
            check($sformatf("mux4 sel%0d", v), 32'(ch_out),  32'(mv[v].exp4));
            check($sformatf("mux3 sel%0d", v), 32'(ch_out3), 32'(mv[v].exp3));
        end
        ch_sel = 2'd1;
        #1;
        check("mux latency hold", 32'(ch_out), 32'h44);
        tick();
        check("mux latency update", 32'(ch_out), 32'h22);

        // Reset in the middle of a frame, then a clean frame.
        fr = {16'hA5C3, 8'h1E};
        for (int i = 0; i < 10; i++) begin
            sh_en  = 1'b1;
            sh_din = fr[23-i];
            tick();
        end
        rst_n  = 1'b0;
        sh_din = fr[13];
        tick();
        check_all_zero("midreset");
        rst_n  = 1'b1;
        sh_en  = 1'b0;
        sh_din = 1'b0;
        tick();
        send_frame(16'hA5C3, 8'h1E, 24);
        check("post reset cfg_out",   32'(cfg_out),   32'hA5C3);
        check("post reset cfg_valid", 32'(cfg_valid), 32'h1);
        check("post reset crc_err",   32'(crc_err),   32'h0);
        check("post reset len_err",   32'(len_err),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
